cic_filter: RTL and testbench



---
 rtl/cic_filter.sv | 83 ++++++++
 tb/tb_cic_filter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cic_filter.sv
// Single-clock CIC core: clock-enable divider, N comb stages, then N integrators.
// The enable pulse is exported so upstream sample sources can run in lock-step.
module cic_filter #(
  parameter int WIDTH     = 16,
  parameter int R         = 100,
  parameter int M         = 1,
  parameter int N         = 1,
  parameter int DIV       = 5,
  parameter int GROWTH    = N * $clog2(R * M),
  parameter int OUT_WIDTH = WIDTH + GROWTH + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in,
  output logic                 clk_en,
  output logic [OUT_WIDTH-1:0] comb_out,
  output logic [OUT_WIDTH-1:0] out
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] in_ext;
  logic [OUT_WIDTH-1:0] comb_in [N];
  logic [OUT_WIDTH-1:0] dly_q   [N][M];
  logic [OUT_WIDTH-1:0] dly_d   [N][M];
  logic [OUT_WIDTH-1:0] comb_q  [N];
  logic [OUT_WIDTH-1:0] comb_d  [N];
  logic [OUT_WIDTH-1:0] acc_q   [N];
  logic [OUT_WIDTH-1:0] acc_d   [N];

  // Gating with rst keeps the pulse low for the whole time reset is held.
  assign clk_en = (cnt_q == CNT_MAX) && rst;
  assign in_ext = {{(OUT_WIDTH - WIDTH){in[WIDTH-1]}}, in};

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
  end

  // Plain modular arithmetic: integrator wrap is cancelled by the comb chain.
  always_comb begin
    comb_in[0] = in_ext;
    for (int j = 1; j < N; j++) begin
      comb_in[j] = comb_q[j-1];
    end
    for (int j = 0; j < N; j++) begin
      comb_d[j]   = comb_in[j] - dly_q[j][M-1];
      dly_d[j][0] = comb_in[j];
      for (int k = 1; k < M; k++) begin
        dly_d[j][k] = dly_q[j][k-1];
      end
    end
    acc_d[0] = acc_q[0] + comb_q[N-1];
    for (int j = 1; j < N; j++) begin
      acc_d[j] = acc_q[j] + acc_q[j-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      for (int j = 0; j < N; j++) begin
        for (int k = 0; k < M; k++) begin
          dly_q[j][k] <= '0;
        end
        comb_q[j] <= '0;
        acc_q[j]  <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (clk_en) begin
        dly_q  <= dly_d;
        comb_q <= comb_d;
        acc_q  <= acc_d;
      end
    end
  end

  assign comb_out = comb_q[N-1];
  assign out      = acc_q[N-1];

endmodule

// File: tb/tb_cic_filter.sv
// Bench for cic_filter (defaults: WIDTH=16, N=1, M=1, DIV=5): vector table plus
// model-driven sequences, expectations queued at drive time and popped after each enable.
module tb_cic_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_s = '0;
  logic        clk_en;
  logic [23:0] comb_out;
  logic [23:0] out;

  int errors = 0;
  int checks = 0;

  logic [15:0] prev;
  logic [23:0] last_comb, last_out;

  typedef struct {
    logic [23:0] c;
    logic [23:0] o;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] v;
    logic [23:0] c;
    logic [23:0] o;
  } vec_t;
  vec_t vecs[6];

  cic_filter dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in_s),
    .clk_en   (clk_en),
    .comb_out (comb_out),
    .out      (out)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] sx(input logic [15:0] v);
    return {{8{v[15]}}, v};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one sample onto the next enabled edge; outputs must hold in between.
  task automatic step(input logic [15:0] v, input logic [23:0] ec, input logic [23:0] eo,
                      input bit tog);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!clk_en && guard < 20) begin
      check("hold_comb", comb_out, last_comb);
      check("hold_out", out, last_out);
      if (tog) in_s = 16'($urandom);
      guard++;
      @(negedge clk);
    end
    check("en_timeout", 24'(clk_en), 24'd1);
    in_s = v;
    e.c  = ec;
    e.o  = eo;
    sb.push_back(e);
    prev = v;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 24'(sb.size()), 24'd1);
    end else begin
      e = sb.pop_front();
      check("comb_out", comb_out, e.c);
      check("out", out, e.o);
      last_comb = e.c;
      last_out  = e.o;
    end
    if (tog) in_s = 16'($urandom);
  endtask

  // Reference for N=1, M=1: comb = x[k]-x[k-1], out = x[k-1].
  task automatic mstep(input logic [15:0] v, input bit tog);
    step(v, sx(v) - sx(prev), sx(prev), tog);
  endtask

  task automatic do_reset();
    int n;
    rst  = 1'b0;
    in_s = '0;
    #1;
    check("rst_clk_en", 24'(clk_en), 24'd0);
    check("rst_comb", comb_out, 24'd0);
    check("rst_out", out, 24'd0);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b1;
    prev      = '0;
    last_comb = '0;
    last_out  = '0;
    sb.delete();
    #1;
    check("rel_clk_en", 24'(clk_en), 24'd0);
    n = 0;
    while (!clk_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_en_edges", 24'(n), 24'd4);
    @(negedge clk);
    check("en_width", 24'(clk_en), 24'd0);
    n = 1;
    while (!clk_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("en_period", 24'(n), 24'd5);
  endtask

  initial begin
    vecs[0] = '{16'd1000,  24'd1000,   24'd0};
    vecs[1] = '{16'd1000,  24'd0,      24'd1000};
    vecs[2] = '{16'd1000,  24'd0,      24'd1000};
    vecs[3] = '{16'hFBFB,  24'hFFF813, 24'd1000};
    vecs[4] = '{16'hFBFB,  24'd0,      24'hFFFBFB};
    vecs[5] = '{16'hFBFB,  24'd0,      24'hFFFBFB};

    #12;
    do_reset();
    for (int i = 0; i < 6; i++) step(vecs[i].v, vecs[i].c, vecs[i].o, 1'b0);

    // Asynchronous reset between edges while out = -1029, then identical replay.
    #3;
    do_reset();
    for (int i = 0; i < 6; i++) step(vecs[i].v, vecs[i].c, vecs[i].o, 1'b0);

    for (int i = 0; i < 4; i++) mstep(16'd500, 1'b1);
    check("hold_500", out, 24'd500);

    for (int i = 0; i < 8; i++) mstep((i % 2 == 0) ? 16'h7FFF : 16'h8000, 1'b0);

    for (int i = 0; i < 10; i++) mstep(16'($urandom), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
